// File: rtl/vga_term_write_vram.sv
// vga_term_write_vram
//   Character-stream writer for the text VRAM. It accepts one byte per
//   valid/ready handshake and keeps a text cursor (col, row, linear address).
//   Printable bytes become single-cycle VRAM write strobes. CR, LF and BS
//   move the cursor. FF sweeps the whole screen with spaces.
//
// Ports
//   i_clk     clock, all logic on the rising edge
//   i_rst     synchronous reset, active-high, overrides every state
//   i_data    input byte
//   i_valid   i_data valid
//   o_ready   block accepts a byte on the next edge if i_valid is high
//   o_we      VRAM write strobe, one cycle per write
//   o_addr    VRAM write address
//   o_wdata   VRAM write data
//   o_cursor  cursor linear address (row*RES_X_MAX + col)
//
// State table
//   S_IDLE  | waiting for a byte, o_ready high once out of reset
//   S_EXEC  | decode captured byte: issue write or move cursor
//   S_DONE  | advance cursor after a printable byte, publish o_cursor
//   S_CLEAR | form-feed sweep, one space written per cycle
module vga_term_write_vram #(
  parameter logic [7:0] RES_X_MAX = 8'd80,
  parameter logic [7:0] RES_Y_MAX = 8'd25
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_we,
  output logic [10:0] o_addr,
  output logic [7:0]  o_wdata,
  output logic [10:0] o_cursor
);

  localparam int unsigned CELLS      = int'(RES_X_MAX) * int'(RES_Y_MAX);
  localparam logic [10:0] LAST_ADDR  = 11'(CELLS - 1);
  localparam logic [7:0]  COL_LAST   = RES_X_MAX - 8'd1;
  localparam logic [7:0]  ROW_LAST   = RES_Y_MAX - 8'd1;
  localparam logic [10:0] ROW_STRIDE = {3'b000, RES_X_MAX};

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TILDE = 8'h7E;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE,
    S_CLEAR
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  col_q, col_d;
  logic [7:0]  row_q, row_d;
  logic [10:0] cur_q, cur_d;
  logic [7:0]  byte_q, byte_d;
  logic [10:0] clr_q, clr_d;

  logic        ready_d;
  logic        we_d;
  logic [10:0] addr_d;
  logic [7:0]  wdata_d;
  logic [10:0] cursor_d;

  logic        accept;
  logic        printable;

  // o_ready is only ever high in S_IDLE, so the handshake alone qualifies accept.
  assign accept    = i_valid && o_ready;
  assign printable = (byte_q >= CH_SPACE) && (byte_q <= CH_TILDE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      col_q    <= 8'd0;
      row_q    <= 8'd0;
      cur_q    <= 11'd0;
      byte_q   <= 8'd0;
      clr_q    <= 11'd0;
      o_ready  <= 1'b0;
      o_we     <= 1'b0;
      o_addr   <= 11'd0;
      o_wdata  <= CH_SPACE;
      o_cursor <= 11'd0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      cur_q    <= cur_d;
      byte_q   <= byte_d;
      clr_q    <= clr_d;
      o_ready  <= ready_d;
      o_we     <= we_d;
      o_addr   <= addr_d;
      o_wdata  <= wdata_d;
      o_cursor <= cursor_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    cur_d    = cur_q;
    byte_d   = byte_q;
    clr_d    = clr_q;
    ready_d  = 1'b0;
    we_d     = 1'b0;
    addr_d   = o_addr;
    wdata_d  = o_wdata;
    cursor_d = o_cursor;

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          byte_d  = i_data;
          ready_d = 1'b0;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_DONE;
        if (printable) begin
          we_d    = 1'b1;
          addr_d  = cur_q;
          wdata_d = byte_q;
        end else begin
          case (byte_q)
            CH_CR: begin
              cur_d = cur_q - {3'b000, col_q};
              col_d = 8'd0;
            end
            CH_LF: begin
              if (row_q == ROW_LAST) begin
                row_d = 8'd0;
                cur_d = {3'b000, col_q};
              end else begin
                row_d = row_q + 8'd1;
                cur_d = cur_q + ROW_STRIDE;
              end
            end
            CH_BS: begin
              // No reverse wrap: backspace at column 0 is a no-op.
              if (col_q != 8'd0) begin
                col_d = col_q - 8'd1;
                cur_d = cur_q - 11'd1;
              end
            end
            CH_FF: begin
              // First sweep write is issued here so the strobe train starts
              // the cycle after decode; clr tracks the address on o_addr.
              clr_d   = 11'd0;
              we_d    = 1'b1;
              addr_d  = 11'd0;
              wdata_d = CH_SPACE;
              state_d = S_CLEAR;
            end
            default: begin
            end
          endcase
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        if (printable) begin
          if (col_q == COL_LAST) begin
            col_d = 8'd0;
            if (row_q == ROW_LAST) begin
              row_d = 8'd0;
              cur_d = 11'd0;
            end else begin
              row_d = row_q + 8'd1;
              cur_d = cur_q + 11'd1;
            end
          end else begin
            col_d = col_q + 8'd1;
            cur_d = cur_q + 11'd1;
          end
        end
        cursor_d = cur_d;
      end

      S_CLEAR: begin
        if (clr_q == LAST_ADDR) begin
          state_d  = S_IDLE;
          ready_d  = 1'b1;
          col_d    = 8'd0;
          row_d    = 8'd0;
          cur_d    = 11'd0;
          cursor_d = 11'd0;
        end else begin
          clr_d   = clr_q + 11'd1;
          we_d    = 1'b1;
          addr_d  = clr_q + 11'd1;
          wdata_d = CH_SPACE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_vga_term_write_vram.sv
// Bench for vga_term_write_vram: directed cursor/boundary steps, a form-feed
// sweep, a randomized byte stream with held-valid stalls, and a reset that
// aborts a sweep. Expected behaviour comes from a column/row model that uses
// modulo arithmetic and a mirror image of the screen.
module tb_vga_term_write_vram;

  localparam int COLS  = 80;
  localparam int ROWS  = 25;
  localparam int CELLS = COLS * ROWS;
  localparam int NRND  = 250;

  logic        i_clk;
  logic        i_rst;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        o_ready;
  logic        o_we;
  logic [10:0] o_addr;
  logic [7:0]  o_wdata;
  logic [10:0] o_cursor;

  int n_checks;
  int n_errors;

  int m_col;
  int m_row;
  bit pending;

  logic [7:0] exp_mem [CELLS];
  logic [7:0] dut_mem [CELLS];
  logic [7:0] rnd [NRND];

  vga_term_write_vram dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_we    (o_we),
    .o_addr  (o_addr),
    .o_wdata (o_wdata),
    .o_cursor(o_cursor)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Sends one byte and checks its whole transaction. With hold_next the next
  // byte is presented with i_valid high while the block is still busy.
  task automatic send_byte(input logic [7:0] b, input int pre_idle,
                           input bit hold_next, input logic [7:0] next_b);
    int         wait_cyc;
    int         n_we;
    int         first_we_k;
    int         ready_k;
    int         exp_we;
    int         exp_addr;
    bit         is_ff;
    bit         contiguous;
    bit         cursor_steady;
    logic [10:0] got_addr;
    logic [7:0]  got_data;
    logic [10:0] cur_before;

    if (!pending) begin
      i_valid = 1'b0;
      repeat (pre_idle) @(negedge i_clk);
      i_valid = 1'b1;
    end
    i_data = b;
    wait_cyc = 0;
    while (!o_ready && wait_cyc < 50) begin
      @(negedge i_clk);
      wait_cyc++;
    end
    check("ready_wait_timeout", (wait_cyc < 50), 1);
    cur_before = o_cursor;
    check("cursor_before", cur_before, m_row * COLS + m_col);

    // Reference model of the byte's effect.
    exp_we = 0;
    exp_addr = 0;
    is_ff = 1'b0;
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_we = 1;
      exp_addr = m_row * COLS + m_col;
      exp_mem[exp_addr] = b;
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
      end
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h0A) begin
      m_row = (m_row + 1) % ROWS;
    end else if (b == 8'h08) begin
      if (m_col > 0) m_col--;
    end else if (b == 8'h0C) begin
      is_ff = 1'b1;
      m_col = 0;
      m_row = 0;
      for (int a = 0; a < CELLS; a++) exp_mem[a] = 8'h20;
    end

    @(negedge i_clk);
    if (hold_next) begin
      i_valid = 1'b1;
      i_data = next_b;
    end else begin
      i_valid = 1'b0;
      i_data = 8'($urandom);
    end

    n_we = 0;
    first_we_k = 0;
    ready_k = 0;
    got_addr = '0;
    got_data = '0;
    contiguous = 1'b1;
    cursor_steady = 1'b1;
    for (int k = 1; k <= 2100; k++) begin
      if (o_we) begin
        if (n_we == 0) begin
          first_we_k = k;
          got_addr = o_addr;
          got_data = o_wdata;
        end
        if (o_addr != 11'(n_we) || o_wdata != 8'h20) contiguous = 1'b0;
        if (int'(o_addr) < CELLS) dut_mem[o_addr] = o_wdata;
        n_we++;
      end
      if (o_ready) begin
        ready_k = k;
        break;
      end
      if (o_cursor !== cur_before) cursor_steady = 1'b0;
      @(negedge i_clk);
    end
    pending = hold_next;

    check("ready_latency", ready_k, is_ff ? 2002 : 3);
    check("we_count", n_we, is_ff ? CELLS : exp_we);
    if (exp_we == 1) begin
      check("we_cycle", first_we_k, 2);
      check("wr_addr", got_addr, exp_addr);
      check("wr_data", got_data, b);
    end
    if (is_ff) begin
      check("clr_first_cycle", first_we_k, 2);
      check("clr_contiguous", contiguous, 1);
    end
    check("cursor_after", o_cursor, m_row * COLS + m_col);
    check("cursor_steady", cursor_steady, 1);
  endtask

  task automatic send(input logic [7:0] b);
    send_byte(b, 0, 1'b0, 8'h00);
  endtask

  initial begin
    int diffs;
    int r;
    int wcnt;
    bit hold;

    n_checks = 0;
    n_errors = 0;
    m_col = 0;
    m_row = 0;
    pending = 1'b0;
    for (int a = 0; a < CELLS; a++) begin
      exp_mem[a] = 8'h00;
      dut_mem[a] = 8'h00;
    end

    // Reset values, with i_valid held high to show it is ignored.
    i_rst = 1'b1;
    i_valid = 1'b1;
    i_data = 8'h41;
    repeat (3) @(negedge i_clk);
    check("rst_ready", o_ready, 0);
    check("rst_we", o_we, 0);
    check("rst_addr", o_addr, 0);
    check("rst_wdata", o_wdata, 8'h20);
    check("rst_cursor", o_cursor, 0);
    i_valid = 1'b0;
    i_rst = 1'b0;
    @(negedge i_clk);
    check("ready_after_rst", o_ready, 1);

    // Single printable, then back to column 0.
    send(8'h41);
    check("cursor_A", o_cursor, 1);
    send(8'h0D);

    // Row wrap: 80 chars then 'B' at address 80.
    for (int i = 0; i < COLS; i++) send(8'h41);
    send(8'h42);
    check("cursor_B", o_cursor, 81);
    send(8'h43);
    send(8'h44);
    check("cursor_83", o_cursor, 83);
    send(8'h0D);
    check("cursor_cr", o_cursor, 80);
    send(8'h0A);
    check("cursor_lf", o_cursor, 160);
    send(8'h08);
    check("cursor_bs_col0", o_cursor, 160);

    // Bottom-right corner and screen wrap.
    for (int i = 0; i < 22; i++) send(8'h0A);
    for (int i = 0; i < COLS - 1; i++) send(8'h78);
    check("cursor_1999", o_cursor, 1999);
    send(8'h5A);
    check("cursor_wrap", o_cursor, 0);
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h79);
    check("cursor_1925", o_cursor, 1925);
    send(8'h0A);
    check("cursor_lf_wrap", o_cursor, 5);
    send(8'h08);
    check("cursor_bs", o_cursor, 4);

    // Full form-feed sweep.
    send(8'h0C);
    check("cursor_ff", o_cursor, 0);

    // Randomized stream with held-valid stalls and ignored bytes.
    for (int i = 0; i < NRND; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3, 4: rnd[i] = 8'($urandom_range(8'h20, 8'h7E));
        5: rnd[i] = 8'h0D;
        6: rnd[i] = 8'h0A;
        7: rnd[i] = 8'h08;
        8: rnd[i] = 8'h07;
        default: begin
          rnd[i] = 8'($urandom);
          if (rnd[i] == 8'h0C) rnd[i] = 8'h07;
        end
      endcase
    end
    rnd[0] = 8'h07;
    rnd[1] = 8'h07;
    rnd[2] = 8'h07;
    for (int i = 0; i < NRND; i++) begin
      hold = (i < NRND - 1) && ($urandom_range(0, 1) == 1);
      if (i < 2) hold = 1'b1;
      send_byte(rnd[i], $urandom_range(0, 3), hold,
                (i < NRND - 1) ? rnd[(i < NRND - 1) ? i + 1 : i] : 8'h00);
    end

    diffs = 0;
    for (int a = 0; a < CELLS; a++)
      if (dut_mem[a] !== exp_mem[a]) diffs++;
    check("vram_image", diffs, 0);

    // Reset in the middle of a sweep.
    i_valid = 1'b0;
    wcnt = 0;
    while (!o_ready && wcnt < 50) begin
      @(negedge i_clk);
      wcnt++;
    end
    i_valid = 1'b1;
    i_data = 8'h0C;
    @(negedge i_clk);
    i_valid = 1'b0;
    wcnt = 0;
    while (!(o_we && o_addr == 11'd1000) && wcnt < 2100) begin
      @(negedge i_clk);
      wcnt++;
    end
    check("clr_reach_1000", (wcnt < 2100), 1);
    i_rst = 1'b1;
    i_valid = 1'b1;
    i_data = 8'h51;
    @(negedge i_clk);
    check("abort_we", o_we, 0);
    check("abort_addr", o_addr, 0);
    check("abort_ready", o_ready, 0);
    check("abort_cursor", o_cursor, 0);
    @(negedge i_clk);
    check("abort_hold_we", o_we, 0);
    i_valid = 1'b0;
    i_rst = 1'b0;
    m_col = 0;
    m_row = 0;
    pending = 1'b0;
    @(negedge i_clk);
    check("abort_ready_release", o_ready, 1);
    send(8'h48);
    send(8'h49);
    check("cursor_post_abort", o_cursor, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_term_write_vram.md
# vga_term_write_vram

Character-stream writer for the text VRAM: the write-side counterpart of the linear VRAM read scanner. Accepts one byte at a time over a valid/ready handshake, keeps a text cursor (column, row, linear address), and turns printable bytes into single-cycle VRAM write strobes. Control bytes move the cursor; form feed sweeps the screen with spaces. Sits between the host byte source (UART receiver) and the VRAM write port.

## Interface
- RES_X_MAX, 8'd80, columns per row
- RES_Y_MAX, 8'd25, rows per screen; RES_X_MAX*RES_Y_MAX must be ≤ 2048 (11-bit address)

- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  synchronous reset, active-high
- i_data  in  8  input byte
- i_valid  in  1  i_data valid
- o_ready  out  1  block can accept a byte this cycle
- o_we  out  1  VRAM write strobe, one cycle per write
- o_addr  out  11  VRAM write address
- o_wdata  out  8  VRAM write data
- o_cursor  out  11  current cursor linear address (row*RES_X_MAX + col)

## Operation
- Internal state: col (8 bit), row (8 bit), cur (11 bit, linear), byte register, clear counter (11 bit). Linear address maintained incrementally: add/subtract only, no multiplier.
- Byte accepted on an edge where i_valid && o_ready; i_data captured into byte register.
- States: IDLE (o_ready=1), EXEC, DONE, CLEAR.
  - IDLE: on accept -> EXEC (o_ready=0 next cycle).
  - EXEC: decode byte.
    - 0x20..0x7E: drive o_we=1, o_addr=cur, o_wdata=byte; -> DONE.
    - 0x0D (CR): cur <= cur - col, col <= 0; -> DONE.
    - 0x0A (LF): if row==RES_Y_MAX-1: row <= 0, cur <= col; else row+1, cur+RES_X_MAX; col unchanged; -> DONE.
    - 0x08 (BS): if col>0: col-1, cur-1; if col==0: no change (no reverse wrap); -> DONE.
    - 0x0C (FF): clear counter <= 0; -> CLEAR.
    - all other values: ignored; -> DONE.
  - DONE: o_we=0; for printable byte advance cursor: col+1, cur+1; if col==RES_X_MAX-1: col <= 0, row+1; if additionally row==RES_Y_MAX-1: row <= 0, cur <= 0 (screen wrap, no scroll). -> IDLE, o_ready=1.
  - CLEAR: each cycle o_we=1, o_addr=clear counter, o_wdata=0x20, counter+1; after address RES_X_MAX*RES_Y_MAX-1 is written: o_we=0, col=row=cur=0, -> IDLE.
- Bytes presented while o_ready=0 are not consumed; source must hold i_data/i_valid.
- o_cursor updates only in DONE and on CLEAR completion; never shows intermediate values.

## Timing
- Reset values: o_ready=0, o_we=0, o_addr=0, o_wdata=8'h20, o_cursor=0, state IDLE, col=row=0. o_ready rises on the first edge after i_rst deasserts.
- All outputs registered.
- Non-clear byte accepted at edge N: o_ready=0 after N; o_we=1 (printable) during cycle after N+1; o_cursor updated and o_ready=1 after N+2. Throughput: one byte per 3 cycles.
- FF accepted at edge N: o_we high for exactly RES_X_MAX*RES_Y_MAX consecutive cycles starting after edge N+1, addresses 0,1,2,… ascending; o_ready=1 and o_cursor=0 one edge after last write.
- i_rst has priority over every state: reset mid-write or mid-clear aborts immediately, outputs take reset values next edge; VRAM left partially written (accepted).
- i_valid ignored while i_rst=1.

## Test plan
- Reset, then send 'A'(0x41) -> one o_we pulse, o_addr=0, o_wdata=0x41, 2 cycles after accept; o_cursor=1, o_ready=1 3 cycles after accept.
- Send 80 × 0x41 then 'B' -> 'B' written at o_addr=80; o_cursor=81 (row 1, col 1).
- Cursor at 83 (row 1, col 3): send 0x0D -> o_cursor=80, no o_we; send 0x0A -> o_cursor=160; send 0x08 at col 0 -> o_cursor stays 160.
- Cursor at 1999: send 'Z' -> write at 1999, o_cursor=0; cursor at row 24 col 5 (1925), send 0x0A -> o_cursor=5.
- Send 0x0C -> exactly 2000 o_we pulses, addresses 0..1999 contiguous, data 0x20, then o_cursor=0, o_ready=1; assert i_rst at write 1000 -> o_we=0, o_addr=0, o_ready=0 next edge, o_ready=1 the edge after release.
- Hold i_valid with 0x07 and random stall patterns -> no o_we for 0x07, each byte consumed exactly once, no byte lost while o_ready=0.
